wb_slave_arbiter: RTL and testbench

Round-robin WISHBONE arbiter that lets up to eight bus masters (CPU data port, DMA, debug bridge) share a single WISHBONE slave such as the GPIO block. A grant is held for the whole bus cycle (`cyc` high), so a master's read-modify-write sequence is never interleaved with another master's accesses. A per-access timeout converts a hung slave into an error termination.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_slave_arbiter_rr_pick.sv | 23 ++
 rtl/wb_slave_arbiter.sv | 89 ++++++++
 tb/tb_wb_slave_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared WISHBONE widths, arbiter state encoding and a sizing helper.
package wb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/wb_slave_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; lowest requester at or after last+1 wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] c;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        valid_o = |req_i;
        idx_o = '0;
        c = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = IW'((int'(last_i) + 1 + i) % N);
            idx_o = req_i[c] ? c : idx_o;
        end
    end
endmodule

// File: rtl/wb_slave_arbiter.sv
// wb_slave_arbiter: round-robin WISHBONE arbiter sharing one slave between up to
// eight masters; grant held for the whole cycle, per-access timeout turns into err.
import wb_pkg::*;

module wb_slave_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic [WB_DAT_W-1:0]             s_dat_i,
    input  logic                            s_ack_i
);
    localparam int IW = clog2(NUM_MASTERS);
    localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pick_vld, act, stb, hit, ack;

    logic [WB_ADR_W-1:0] adr_a [NUM_MASTERS];
    logic [WB_DAT_W-1:0] dat_a [NUM_MASTERS];
    logic [WB_SEL_W-1:0] sel_a [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign adr_a[g] = m_adr_i[WB_ADR_W*g +: WB_ADR_W];
        assign dat_a[g] = m_dat_i[WB_DAT_W*g +: WB_DAT_W];
        assign sel_a[g] = m_sel_i[WB_SEL_W*g +: WB_SEL_W];
    end

    rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .valid_o(pick_vld),
        .idx_o  (pick)
    );

    // The slave side drops in the same cycle the granted master releases cyc.
    always_comb begin
        act = state_q == ST_BUSY && m_cyc_i[grant_q];
        stb = act && m_stb_i[grant_q];
        hit = TIMEOUT != 0 && stb && tcnt_q == TW'(TIMEOUT);
        ack = stb && s_ack_i;
        state_d = state_q == ST_IDLE ? (pick_vld ? ST_BUSY : ST_IDLE)
                                     : (m_cyc_i[grant_q] ? ST_BUSY : ST_IDLE);
        grant_d = (state_q == ST_IDLE && pick_vld) ? pick : grant_q;
        last_d  = (state_q == ST_IDLE && pick_vld) ? pick : last_q;
        tcnt_d  = (TIMEOUT != 0 && stb && !s_ack_i && !hit) ? tcnt_q + TW'(1) : '0;
        s_cyc_o = act;
        s_stb_o = stb && !hit;
        s_we_o  = act && m_we_i[grant_q];
        s_adr_o = act ? adr_a[grant_q] : '0;
        s_sel_o = act ? sel_a[grant_q] : '0;
        s_dat_o = act ? dat_a[grant_q] : '0;
        m_dat_o = act ? s_dat_i : '0;
        m_ack_o = NUM_MASTERS'(ack) << grant_q;
        m_err_o = NUM_MASTERS'(hit && !s_ack_i) << grant_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_wb_slave_arbiter.sv
// tb_wb_slave_arbiter: directed checks of arbitration, bus lock, timeout and reset
// against a GPIO-like slave register that acks one cycle after strobe.
module tb_wb_slave_arbiter;
    logic         clk, rst, slave_en;
    logic [3:0]   cyc, stb, we;
    logic [127:0] adr, dat;
    logic [15:0]  sel;
    logic [31:0]  m_dat, s_adr, s_dat, sreg;
    logic [3:0]   m_ack, m_err, s_sel;
    logic         s_cyc, s_stb, s_we, ack_q;
    int           n_chk, n_err;

    wb_slave_arbiter #(.NUM_MASTERS(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_sel_i(sel), .m_dat_i(dat),
        .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_dat),
        .s_dat_i(sreg), .s_ack_i(ack_q)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Slave: single register, write applied at the edge that raises ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            sreg  <= 32'hA5A5_0000;
        end else begin
            ack_q <= s_cyc && s_stb && !ack_q && slave_en;
            if (s_cyc && s_stb && !ack_q && slave_en && s_we)
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) sreg[8*b +: 8] <= s_dat[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [3:0] se, input logic [31:0] d);
        cyc[k] = c;
        stb[k] = s;
        we[k]  = w;
        adr[32*k +: 32] = a;
        sel[4*k +: 4]   = se;
        dat[32*k +: 32] = d;
    endtask

    task automatic release_m(input int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order [3];
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        slave_en = 1'b1;
        cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_adr", s_adr, 0);
        check("rst_m_ack", m_ack, 0);
        check("rst_m_err", m_err, 0);
        check("rst_m_dat", m_dat, 0);
        rst = 1'b0;

        // Single master write then readback
        drive(2, 1, 1, 1, 32'h0, 4'b0001, 32'h0000_00FF);
        #1 check("single_latency", s_cyc, 0);
        @(negedge clk);
        check("single_s_cyc", s_cyc, 1);
        check("single_s_stb", s_stb, 1);
        check("single_s_we", s_we, 1);
        check("single_s_adr", s_adr, 32'h0);
        check("single_s_sel", s_sel, 4'b0001);
        check("single_s_dat", s_dat, 32'h0000_00FF);
        check("single_no_ack", m_ack, 0);
        @(negedge clk);
        check("single_ack", m_ack, 4'b0100);
        release_m(2);
        @(negedge clk);
        check("single_ack_gone", m_ack, 0);
        check("single_idle", s_cyc, 0);
        drive(2, 1, 1, 0, 32'h0, 4'b1111, 32'h0);
        @(negedge clk);
        check("rd_s_we", s_we, 0);
        @(negedge clk);
        check("rd_ack", m_ack, 4'b0100);
        check("rd_data", m_dat, 32'hA5A5_00FF);
        check("rd_byte0", m_dat[7:0], 8'hFF);
        release_m(2);
        @(negedge clk);

        // Simultaneous requests from 0, 1, 3 right after reset
        do_reset();
        order = '{0, 1, 3};
        for (int k = 0; k < 4; k++)
            if (k != 2) drive(k, 1, 1, 0, 32'h10 * k + 32'h4, 4'b1111, 32'h0);
        foreach (order[i]) begin
            @(negedge clk);
            check($sformatf("rr%0d_adr", i), s_adr, 32'h10 * order[i] + 32'h4);
            check($sformatf("rr%0d_wait", i), m_ack, 0);
            @(negedge clk);
            check($sformatf("rr%0d_ack", i), m_ack, 4'b1 << order[i]);
            release_m(order[i]);
            @(negedge clk);
            check($sformatf("rr%0d_dead", i), s_cyc, 0);
        end

        // Bus lock: master 1 reads then writes under one cyc while master 0 waits
        drive(1, 1, 1, 0, 32'h0, 4'b1111, 32'h0);
        @(negedge clk);
        check("lock_grant1", s_adr, 32'h0);
        drive(0, 1, 1, 0, 32'h40, 4'b1111, 32'h0);
        @(negedge clk);
        check("lock_rd_ack", m_ack, 4'b0010);
        check("lock_rd_data", m_dat, 32'hA5A5_0000);
        stb[1] = 1'b0;
        @(negedge clk);
        check("lock_held_cyc", s_cyc, 1);
        check("lock_held_stb", s_stb, 0);
        check("lock_m0_waits", m_ack, 0);
        drive(1, 1, 1, 1, 32'h0, 4'b1111, 32'h1122_3344);
        @(negedge clk);
        check("lock_wr_ack", m_ack, 4'b0010);
        release_m(1);
        @(negedge clk);
        check("lock_dead", s_cyc, 0);
        @(negedge clk);
        check("lock_m0_adr", s_adr, 32'h40);
        @(negedge clk);
        check("lock_m0_ack", m_ack, 4'b0001);
        check("lock_m0_data", m_dat, 32'h1122_3344);
        release_m(0);
        @(negedge clk);

        // Timeout with a silent slave
        slave_en = 1'b0;
        drive(0, 1, 1, 0, 32'h0, 4'b1111, 32'h0);
        @(negedge clk);
        check("to_stb_rise", s_stb, 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", i), {s_stb, m_err}, {1'b1, 4'b0000});
        end
        @(negedge clk);
        check("to_err", m_err, 4'b0001);
        check("to_stb_low", s_stb, 0);
        check("to_no_ack", m_ack, 0);
        @(negedge clk);
        check("to_err_1cyc", m_err, 0);
        check("to_grant_kept", {s_cyc, s_stb}, 2'b11);
        release_m(0);
        @(negedge clk);

        // Asynchronous reset while master 3 owns the bus
        drive(3, 1, 1, 0, 32'h34, 4'b1111, 32'h0);
        @(negedge clk);
        check("mid_busy", s_cyc, 1);
        check("mid_adr3", s_adr, 32'h34);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cyc", s_cyc, 0);
        check("mid_rst_stb", s_stb, 0);
        check("mid_rst_adr", s_adr, 0);
        check("mid_rst_ack_err", {m_ack, m_err}, 0);
        drive(0, 1, 1, 0, 32'h04, 4'b1111, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_tie_m0", s_adr, 32'h04);
        check("mid_tie_cyc", s_cyc, 1);
        release_m(0);
        release_m(3);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
